// File: rtl/reload_pkg.sv
// reload_pkg: shared definitions for the reload_shadow slice.
//   RELOAD_WIDTH      default width of a reload value / observed count
//   RELOAD_DEFAULT_N  reload value driven after reset
//   reload_t          RELOAD_WIDTH-bit unsigned reload value
//   ptr_width()       ceil(log2(depth)), used for queue pointers and counts
package reload_pkg;

    localparam int RELOAD_WIDTH = 4;
    localparam logic [RELOAD_WIDTH-1:0] RELOAD_DEFAULT_N = 4'd9;

    typedef logic [RELOAD_WIDTH-1:0] reload_t;

    function automatic int ptr_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/reload_queue.sv
// reload_queue: DEPTH-entry FIFO holding pending reload values.
// All state changes on the falling edge of clk; synchronous active-low reset.
//   clk, rst_n  clock / synchronous active-low reset
//   flush       empties the queue, overriding push and pop on that edge
//   push, din   append din at the tail (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   dout        current head entry (meaningless while count == 0)
//   count       number of stored entries, 0..DEPTH
//   full        count == DEPTH
module reload_queue
    import reload_pkg::*;
#(
    parameter int WIDTH = RELOAD_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic [ptr_width(DEPTH):0] count,
    output logic                      full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(negedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only read once count covers them.
    always_ff @(negedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/reload_shadow.sv
// reload_shadow: shadow register feeding the N input of a down counter.
// New reload values arrive over valid/ready and are queued; the head of the
// queue is committed to n_out only at a period boundary so a running count
// is never disturbed. All state changes on the falling edge of clk.
//   clk, rst_n   clock / synchronous active-low reset (falling edge)
//   load_data    new reload value, accepted when load_valid && load_ready
//   load_valid   load_data is valid
//   load_ready   queue has room (low while rst_n is low)
//   cnt          live count from the downstream counter
//   n_out        active reload value for the counter
//   reload_evt   registered pulse: the counter reloaded on the last edge
//   pend         number of queued, uncommitted values
//   flush        (only with RELOAD_SHADOW_FLUSH_EN) empties the queue
// Build option: define RELOAD_SHADOW_FLUSH_EN to add the flush input.
module reload_shadow
    import reload_pkg::*;
#(
    parameter int               WIDTH     = RELOAD_WIDTH,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] DEFAULT_N = WIDTH'(RELOAD_DEFAULT_N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          load_data,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [WIDTH-1:0]          cnt,
    output logic [WIDTH-1:0]          n_out,
    output logic                      reload_evt,
    output logic [ptr_width(DEPTH):0] pend
`ifdef RELOAD_SHADOW_FLUSH_EN
    ,
    input  logic                      flush
`endif
);

    logic             flush_act;
    logic             q_full;
    logic [WIDTH-1:0] q_head;
    logic             cnt_is_zero;
    logic             cnt_is_one;
    logic             commit_cond;
    logic             do_commit;

`ifdef RELOAD_SHADOW_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Ready ignores a same-edge commit, so a full queue never accepts.
    assign load_ready = rst_n && !q_full;

    assign cnt_is_zero = (cnt == '0);
    assign cnt_is_one  = (cnt == WIDTH'(1));

    // cnt == 1: the counter reaches 0 this edge and reloads on the next one.
    // cnt == 0 with n_out == 0: the counter is stuck reloading zero.
    assign commit_cond = cnt_is_one || (cnt_is_zero && (n_out == '0));
    assign do_commit   = commit_cond && (pend != '0) && !flush_act;

    reload_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_act),
        .push  (load_valid && load_ready),
        .pop   (do_commit),
        .din   (load_data),
        .dout  (q_head),
        .count (pend),
        .full  (q_full)
    );

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            n_out      <= DEFAULT_N;
            reload_evt <= 1'b0;
        end else begin
            reload_evt <= cnt_is_zero;
            if (do_commit) begin
                n_out <= q_head;
            end
        end
    end

endmodule

// File: tb/tb_reload_shadow.sv
// tb_reload_shadow: randomized, scoreboard-checked bench for reload_shadow.
// The bench plays the down counter (cnt) from its own reference model and
// predicts n_out, pend, reload_evt and load_ready for every falling edge.
// Build option: RELOAD_SHADOW_FLUSH_EN enables the flush scenarios.
module tb_reload_shadow;
    import reload_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int PW    = ptr_width(DEPTH);
    localparam reload_t DEF_N = 4'd9;

    logic    clk;
    logic    rst_n;
    logic    load_valid;
    logic    load_ready;
    logic    reload_evt;
    reload_t load_data;
    reload_t cnt;
    reload_t n_out;
    logic [PW:0] pend;
`ifdef RELOAD_SHADOW_FLUSH_EN
    logic    flush;
`endif

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        reload_t n;
        int      pend;
        logic    evt;
        logic    rdy;
        int      cyc;
    } exp_t;

    exp_t    expq[$];

    // Reference model state: pending values, active N, counter value.
    reload_t mq[$];
    reload_t m_n;
    reload_t m_cnt;
    logic    accepted;

    reload_shadow #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .DEFAULT_N (DEF_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .cnt        (cnt),
        .n_out      (n_out),
        .reload_evt (reload_evt),
`ifdef RELOAD_SHADOW_FLUSH_EN
        .flush      (flush),
`endif
        .pend       (pend)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int cyc,
                               input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    // Monitor: the DUT presents new state every falling edge; sample it on
    // the rising edge and compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("n_out",      e.cyc, 32'(n_out),      32'(e.n));
                checkOutput("pend",       e.cyc, 32'(pend),       32'(e.pend));
                checkOutput("reload_evt", e.cyc, 32'(reload_evt), 32'(e.evt));
                checkOutput("load_ready", e.cyc, 32'(load_ready), 32'(e.rdy));
            end
        end
    end

    // Drive one edge's worth of inputs and predict the result of that edge.
    task automatic applyStimulus(input logic r, input logic v, input reload_t d, input logic f);
        exp_t    e;
        reload_t n_before;
        logic    rdy;
        logic    commit;
        @(posedge clk);
        #1;
        rst_n      = r;
        load_valid = v;
        load_data  = d;
`ifdef RELOAD_SHADOW_FLUSH_EN
        flush      = f;
`endif
        cnt        = m_cnt;
        n_before   = m_n;
        accepted   = 1'b0;
        if (!r) begin
            mq.delete();
            m_n   = DEF_N;
            e.evt = 1'b0;
        end else begin
            e.evt = (m_cnt == 4'd0);
            rdy   = (mq.size() < DEPTH);
            if (f) begin
                mq.delete();
            end else begin
                commit = ((m_cnt == 4'd1) || (m_cnt == 4'd0 && m_n == 4'd0)) && (mq.size() > 0);
                if (commit) m_n = mq.pop_front();
                if (v && rdy) begin
                    mq.push_back(d);
                    accepted = 1'b1;
                end
            end
        end
        e.n    = m_n;
        e.pend = mq.size();
        e.rdy  = r && (mq.size() < DEPTH);
        e.cyc  = cycle;
        expq.push_back(e);
        cycle++;
        // The counter reloads the N it saw before this edge.
        m_cnt = (m_cnt == 4'd0) ? n_before : m_cnt - 4'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic pushHold(input reload_t d);
        int k;
        k = 0;
        do begin
            applyStimulus(1'b1, 1'b1, d, 1'b0);
            k++;
        end while (!accepted && k < 40);
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout value %0d got not-accepted expected accepted", d);
        end
    endtask

    task automatic waitCnt(input reload_t value, input int bound);
        for (int i = 0; i < bound && m_cnt != value; i++) idle(1);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 4'd0;
        cnt        = 4'd0;
`ifdef RELOAD_SHADOW_FLUSH_EN
        flush      = 1'b0;
`endif
        m_cnt      = 4'd0;
        m_n        = DEF_N;

        $display("[TB] reset and free-running period of 10");
        repeat (3) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        idle(25);

        $display("[TB] boundary commit of 5");
        waitCnt(4'd7, 20);
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b0);
        idle(20);

        $display("[TB] backpressure 3, 6, 2");
        pushHold(4'd3);
        pushHold(4'd6);
        pushHold(4'd2);
        idle(40);

        $display("[TB] zero period then release with 4");
        pushHold(4'd0);
        idle(30);
        pushHold(4'd4);
        idle(15);

        $display("[TB] reset with two pending values");
        waitCnt(4'd3, 20);
        pushHold(4'd7);
        pushHold(4'd8);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        idle(25);

`ifdef RELOAD_SHADOW_FLUSH_EN
        $display("[TB] flush on a commit edge");
        waitCnt(4'd3, 20);
        pushHold(4'd1);
        pushHold(4'd2);
        waitCnt(4'd1, 20);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
        idle(15);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic    r;
            logic    v;
            logic    f;
            reload_t d;
            r = ($urandom_range(0, 49) != 0);
            v = 1'($urandom_range(0, 1));
            d = reload_t'($urandom_range(0, 6));
`ifdef RELOAD_SHADOW_FLUSH_EN
            f = ($urandom_range(0, 29) == 0);
`else
            f = 1'b0;
`endif
            applyStimulus(r, v, d, f);
        end

        @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", cycle, 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reload_shadow.md
# reload_shadow

Upstream feeder for the `down_count` stage: accepts new reload values N over a valid/ready handshake and queues them. Drives the counter's `N` input and swaps in the next queued value only at a period boundary, so the running count is never disturbed mid-period. It also flags each reload event for downstream logic.

## Interface
- `WIDTH`, default 4: width of reload value and observed count.
- `DEPTH`, default 2: pending-value queue depth; power of two, ≥ 2.
- `DEFAULT_N`, default 4'd9: value driven on `n_out` after reset.

- `clk` in 1: single clock. All state updates on the falling edge, matching `down_count`.
- `rst_n` in 1: synchronous, active-low reset, sampled on the falling edge of `clk`.
- `load_data` in WIDTH: new reload value.
- `load_valid` in 1: `load_data` is valid.
- `load_ready` out 1: queue can accept a value.
- `cnt` in WIDTH: live count from the downstream counter's output.
- `n_out` out WIDTH: active reload value; wire this to the counter's `N`.
- `reload_evt` out 1: one-cycle pulse marking that the counter reloaded.
- `pend` out clog2(DEPTH)+1: number of queued, uncommitted values.
- `flush` in 1: present only with `RELOAD_SHADOW_FLUSH_EN`.

## Operation
- **Push:** occurs on an edge where `load_valid && load_ready`; appends `load_data` to the queue tail.
  - `load_ready = rst_n && (pend != DEPTH)`. It is combinational and does not depend on a same-edge commit, so a full queue never accepts, even while popping.
- **Commit condition:** `C = (cnt == 1) || (cnt == 0 && n_out == 0)`.
- **Commit:** on an edge where C holds and `pend > 0`, pop the queue head into `n_out`.
  - For the `cnt == 1` case: the counter moves 1→0 on the same edge, then loads the new `n_out` on the following edge. The old period completes intact.
  - For the `n_out == 0` case: the counter is stuck reloading 0. The commit releases it, and the counter loads the new value on the next edge.
- **No commit:** if C holds with the queue empty, `n_out` holds its value.
- **Push and commit on the same edge:**
  - Queue empty: only the push occurs. No bypass into `n_out`; the pushed value waits for the next C.
  - Queue non-empty: the push and the pop both occur and `pend` is unchanged.
- **reload_evt:** registered; set to 1 on an edge where `cnt == 0` (the counter is reloading on that same edge), otherwise 0.
- **Width rules:** values are unsigned WIDTH bits. There is no range check; 0 is legal and means "hold at 0".
- **Queue pointers:** wrap modulo DEPTH.

## Timing
- **Reset values:**
  - `n_out = DEFAULT_N`
  - `pend = 0`
  - `reload_evt = 0`
  - `load_ready = 0` while `rst_n` is low, 1 on the first edge after release.
  - Queue contents are don't-care.
- **Reset mid-operation:** discards all queued values and returns `n_out` to `DEFAULT_N` on that edge. The counter itself has no reset and continues with the new `n_out`.
- **Push-to-visibility latency:** 1 edge (`pend` increments on the push edge).
- **Commit-to-counter latency:** 1 edge after the commit edge.
- **reload_evt:** high for exactly the clock period following the reload edge.

## Configuration
- **`RELOAD_SHADOW_FLUSH_EN` defined:** adds the `flush` input.
  - `flush` high on an edge empties the queue (`pend = 0`) and suppresses any push or commit on that edge.
  - `n_out` keeps its value.
  - Reset has priority over flush.
- **Not defined:** no `flush` port; the queue empties only by commit or reset.

## Structure
- **Package `reload_pkg`:**
  - `WIDTH` default
  - `DEFAULT_N`
  - the pointer-width function (clog2)
  - typedef `reload_t` for a WIDTH-bit value
- **Sub-module `reload_queue`:** the DEPTH-entry FIFO (push, pop, count, flush).
- **`reload_shadow` itself:** holds the commit logic, the `n_out` register and the `reload_evt` register.

## Test plan
- **Reset release:** reset, then release with `cnt` looping under `N = 9` → `n_out = 9` throughout, `reload_evt` pulses every 10 edges, `pend = 0`.
- **Boundary commit:** push 5 while the counter is at 7 → `n_out` stays 9 until the edge where `cnt = 1`, then becomes 5; the counter sequence is 0, 5, 4, … .
- **Backpressure:** push 3, 6, 2 back-to-back with `DEPTH = 2` → `load_ready` drops after the second push and the third is held. Commits apply 3, then 6 at successive boundaries, and 2 is accepted once space frees.
- **Zero period:** `n_out = 0`, counter stuck at 0, push 4 → commit on the next edge; the counter loads 4 one edge later and `reload_evt` stops pulsing every edge.
- **Reset mid-operation:** reset with `pend = 2` → `pend = 0` and `n_out = DEFAULT_N` on the reset edge; the queued values are never applied.
- **Flush (`RELOAD_SHADOW_FLUSH_EN`):** assert `flush` with `pend = 2` on a commit edge → `pend = 0` and `n_out` unchanged.
